pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 16: width of the payload field, carried unchanged across the stage.
REQ-002 Parameter CTRL_W, default 13: width of the control field, which is forced to zero whenever the stage emits a bubble.
REQ-003 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  upstream offers a word.
REQ-006 in_ready  output  1  stage can accept a word; registered.
REQ-007 in_data  input  DATA_W  upstream payload.
REQ-008 in_ctrl  input  CTRL_W  upstream control bits (wren, write, PC_load and similar).
REQ-009 flush  input  1  discards all held words.
REQ-010 out_valid  output  1  stage presents a word.
REQ-011 out_ready  input  1  downstream accepts the presented word.
REQ-012 out_data  output  DATA_W  presented payload.
REQ-013 out_ctrl  output  CTRL_W  presented control bits; zero when out_valid=0.
REQ-014 stall_cnt  output  16  count of downstream-stall cycles.

Function
REQ-015 Transfers: in_valid&&in_ready is an accept; out_valid&&out_ready is a retire.
REQ-016 Storage: a main slot (drives the outputs) plus a skid slot.
REQ-017 States: EMPTY (no slot valid), ONE (main valid), TWO (main and skid valid).
REQ-018 From EMPTY: an accept loads main and moves to ONE. Latency is 1 cycle from accept to out_valid.
REQ-019 From ONE:
- accept only: load skid, move to TWO.
- retire only: move to EMPTY.
- accept and retire together: load main, stay in ONE.
REQ-020 From TWO: a retire moves skid into main and moves to ONE. No accept is possible in TWO.
REQ-021 in_ready SHALL be 1 exactly when the state is not TWO. It SHALL be a register output with no combinational path from out_ready.
REQ-022 Order: words SHALL retire in accept order, with none lost or duplicated.
REQ-023 Bubble: when out_valid=0, out_ctrl SHALL be all-zero; out_data holds its last value.
REQ-024 Flush: on a flush cycle, the next state SHALL be EMPTY with out_ctrl zeroed.
- flush takes priority over a simultaneous accept or retire; the accepted word is dropped.
- in_ready SHALL read 1 the cycle after a flush.
REQ-025 Stall count:
- stall_cnt increments by 1 on each cycle with out_valid=1 and out_ready=0.
- it saturates at 16'hFFFF.
- flush does not clear it.
REQ-026 out_valid, out_data and out_ctrl are registered outputs with no combinational input-to-output path.

Reset
REQ-027 While RST=1 at a CLK edge:
- the state SHALL become EMPTY.
- out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0.
- in_ready=1 on the following cycle.
REQ-028 RST SHALL override flush and all transfers.
REQ-029 RST asserted mid-transfer SHALL discard both slots.

Configuration
REQ-030 Macro PIPE_STALL_COUNT_EN:
- defined: the stall counter is implemented per REQ-025.
- undefined: no counter flops exist and stall_cnt is tied to 16'h0000.
- the port list is identical in both builds.

Structure
REQ-031 A shared package pipe_pkg SHALL hold:
- the state enum (EMPTY, ONE, TWO).
- the constant STALL_CNT_W=16.
- the default widths DATA_W_DEF=16 and CTRL_W_DEF=13.
REQ-032 Sub-module pipe_slot (one valid+ctrl+data register with load/clear) SHALL be instantiated twice, as main and skid.

Verification
REQ-033 Fill and drain, out_ready=1:
- stimulus: in_data 0x0001..0x0008 on consecutive cycles.
- response: out_data 0x0001..0x0008 one cycle later, in_ready constantly 1.
REQ-034 Back-pressure, out_ready=0 with two words 0x00AA, 0x00BB accepted:
- in_ready=0 after the second accept; state TWO.
- after out_ready=1: 0x00AA then 0x00BB retire on consecutive cycles.
- stall_cnt equals the number of stalled cycles.
REQ-035 Flush in TWO together with in_valid=1 (0x00CC):
- next cycle out_valid=0, out_ctrl=0, in_ready=1.
- 0x00CC never appears.
REQ-036 RST asserted in state ONE with in_valid=1:
- all outputs at reset values the next cycle.
- stall_cnt=0.
REQ-037 Saturation: out_valid=1, out_ready=0 held for 70000 cycles gives stall_cnt=16'hFFFF (macro defined) or 0 (macro undefined).
REQ-038 Bubble: in_valid=0 with in_ctrl=all-ones gives out_ctrl=0 and out_valid=0 on every cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Types and constants shared by the pipeline stage register and its slots.
//   stage_state_t : occupancy of the stage (EMPTY, ONE, TWO)
//   STALL_CNT_W   : width of the downstream-stall counter
//   DATA_W_DEF    : default payload width
//   CTRL_W_DEF    : default control-field width
// -----------------------------------------------------------------------------
package pipe_pkg;

   localparam int STALL_CNT_W = 16;
   localparam int DATA_W_DEF  = 16;
   localparam int CTRL_W_DEF  = 13;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } stage_state_t;

endpackage : pipe_pkg

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One holding register of the stage: a valid bit, a control field and a
// payload field. Priority is RST > clear > load. A clear drops the word and
// zeroes the control bits but keeps the payload, so a bubble never carries
// live control while the data bus stays quiet.
//   CLK    : clock, rising edge
//   RST    : synchronous active-high reset, zeroes everything
//   load   : capture d_ctrl/d_data and mark the slot valid
//   clear  : invalidate the slot and zero its control field
//   d_ctrl : control bits to capture
//   d_data : payload to capture
//   valid  : slot holds a word
//   ctrl   : held control bits (zero when not valid)
//   data   : held payload
// -----------------------------------------------------------------------------
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              load,
   input  logic              clear,
   input  logic [CTRL_W-1:0] d_ctrl,
   input  logic [DATA_W-1:0] d_data,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);

   // NOTE: state is written with non-blocking assignments only, so every
   // flop samples values from before the edge regardless of block order.
   always_ff @(posedge CLK) begin
      if (RST) begin
         // NOTE: the payload is reset too; it is visible on out_data and the
         // reset value of that port is defined as zero.
         valid <= 1'b0;
         ctrl  <= '0;
         data  <= '0;
      end else if (clear) begin
         valid <= 1'b0;
         ctrl  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         ctrl  <= d_ctrl;
         data  <= d_data;
      end
   end

endmodule : pipe_slot

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Valid/ready pipeline stage with a skid slot. The main slot drives the
// outputs directly; the skid slot absorbs the word accepted in the cycle the
// downstream stalls, which lets in_ready be a plain register with no path
// from out_ready.
//
// Configuration macro: PIPE_STALL_COUNT_EN
//   defined   : stall_cnt counts cycles with out_valid=1 and out_ready=0,
//               saturating at all-ones; flush does not clear it.
//   undefined : no counter flops; stall_cnt is tied to zero.
//
// Ports:
//   CLK       : clock, rising edge
//   RST       : synchronous active-high reset, overrides flush and transfers
//   in_valid  : upstream offers a word
//   in_ready  : stage can accept (registered, 0 only when both slots full)
//   in_data   : upstream payload
//   in_ctrl   : upstream control bits
//   flush     : discard all held words, beats any simultaneous transfer
//   out_valid : stage presents a word
//   out_ready : downstream accepts the presented word
//   out_data  : presented payload (holds last value during a bubble)
//   out_ctrl  : presented control bits (zero during a bubble)
//   stall_cnt : downstream-stall cycle count
// -----------------------------------------------------------------------------
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      in_data,
   input  logic [CTRL_W-1:0]      in_ctrl,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic [CTRL_W-1:0]      out_ctrl,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   stage_state_t      state;
   stage_state_t      next_state;

   logic              accept;
   logic              retire;

   logic              main_load;
   logic              main_clear;
   logic              main_from_skid;
   logic [CTRL_W-1:0] main_d_ctrl;
   logic [DATA_W-1:0] main_d_data;

   logic              skid_load;
   logic              skid_clear;
   logic              skid_valid;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;

   assign accept = in_valid && in_ready;
   assign retire = out_valid && out_ready;

   // NOTE: every signal written here gets a default first, so no path
   // through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      next_state     = state;
      main_load      = 1'b0;
      main_clear     = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      skid_clear     = 1'b0;

      if (flush) begin
         next_state = EMPTY;
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else begin
         unique case (state)
            EMPTY: begin
               if (accept) begin
                  main_load  = 1'b1;
                  next_state = ONE;
               end
            end
            ONE: begin
               if (accept && retire) begin
                  main_load = 1'b1;
               end else if (accept) begin
                  skid_load  = 1'b1;
                  next_state = TWO;
               end else if (retire) begin
                  main_clear = 1'b1;
                  next_state = EMPTY;
               end
            end
            TWO: begin
               // in_ready is low here, so only a retire can happen.
               if (retire && skid_valid) begin
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
                  skid_clear     = 1'b1;
                  next_state     = ONE;
               end
            end
            default: begin
               next_state = EMPTY;
               main_clear = 1'b1;
               skid_clear = 1'b1;
            end
         endcase
      end
   end

   assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
   assign main_d_data = main_from_skid ? skid_data : in_data;

   // in_ready is computed from the next state so it is a true register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= EMPTY;
         in_ready <= 1'b1;
      end else begin
         state    <= next_state;
         in_ready <= (next_state != TWO);
      end
   end

   pipe_slot #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
   ) u_main (
      .CLK    (CLK),
      .RST    (RST),
      .load   (main_load),
      .clear  (main_clear),
      .d_ctrl (main_d_ctrl),
      .d_data (main_d_data),
      .valid  (out_valid),
      .ctrl   (out_ctrl),
      .data   (out_data)
   );

   pipe_slot #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
   ) u_skid (
      .CLK    (CLK),
      .RST    (RST),
      .load   (skid_load),
      .clear  (skid_clear),
      .d_ctrl (in_ctrl),
      .d_data (in_data),
      .valid  (skid_valid),
      .ctrl   (skid_ctrl),
      .data   (skid_data)
   );

`ifdef PIPE_STALL_COUNT_EN
   logic [STALL_CNT_W-1:0] stall_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_q <= '0;
      end else if (out_valid && !out_ready && (stall_q != '1)) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Self-checking bench for pipe_stage_reg. A queue of at most two words models
// the stage; outputs follow from the queue head, the stall counter from the
// queue occupancy and out_ready. Directed scenarios are followed by random
// traffic and a long saturation run. Honours PIPE_STALL_COUNT_EN.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

   localparam int DATA_W = 16;
   localparam int CTRL_W = 13;

`ifdef PIPE_STALL_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic              CLK;
   logic              RST;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic [15:0]       stall_cnt;

   pipe_stage_reg #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl),
      .stall_cnt (stall_cnt)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // ---------------- reference model ----------------
   typedef struct {
      logic [CTRL_W-1:0] c;
      logic [DATA_W-1:0] d;
   } word_t;

   word_t             m_q[$];
   logic [DATA_W-1:0] m_data;
   int unsigned       m_stall;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs, advance the model across the edge, then
   // optionally compare every output with the model.
   task automatic step(input logic rst, input logic iv, input logic [DATA_W-1:0] id,
                       input logic [CTRL_W-1:0] ic, input logic fl, input logic ordy,
                       input bit chk);
      word_t w;
      bit    ret;
      bit    acc;
      RST       = rst;
      in_valid  = iv;
      in_data   = id;
      in_ctrl   = ic;
      flush     = fl;
      out_ready = ordy;
      @(posedge CLK);
      if (rst) begin
         m_q.delete();
         m_data  = '0;
         m_stall = 0;
      end else begin
         if (CNT_EN && m_q.size() > 0 && !ordy && m_stall < 32'hFFFF) m_stall++;
         if (fl) begin
            m_q.delete();
         end else begin
            ret = (m_q.size() > 0) && ordy;
            acc = iv && (m_q.size() < 2);
            if (ret) void'(m_q.pop_front());
            if (acc) begin
               w.c = ic;
               w.d = id;
               m_q.push_back(w);
            end
         end
         if (m_q.size() > 0) m_data = m_q[0].d;
      end
      #1;
      if (chk) begin
         check("out_valid", {31'b0, out_valid}, {31'b0, m_q.size() > 0});
         check("in_ready",  {31'b0, in_ready},  {31'b0, m_q.size() < 2});
         check("out_ctrl",  32'(out_ctrl), (m_q.size() > 0) ? 32'(m_q[0].c) : 32'h0);
         check("out_data",  32'(out_data), 32'(m_data));
         check("stall_cnt", 32'(stall_cnt), m_stall);
      end
   endtask

   logic [CTRL_W-1:0] ones_ctrl;

   initial begin
      ones_ctrl = '1;
      RST = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
      flush = 1'b0; out_ready = 1'b0;

      // Reset state
      step(1, 1, 16'h1234, 13'h1ABC, 1, 0, 1);
      step(1, 0, '0, '0, 0, 0, 1);
      check("rst_out_valid", {31'b0, out_valid}, 32'h0);
      check("rst_in_ready",  {31'b0, in_ready},  32'h1);
      check("rst_out_data",  32'(out_data),  32'h0);
      check("rst_out_ctrl",  32'(out_ctrl),  32'h0);
      check("rst_stall_cnt", 32'(stall_cnt), 32'h0);

      // Fill and drain with out_ready=1: each word appears one cycle later
      for (int i = 1; i <= 8; i++) begin
         step(0, 1, 16'(i), 13'(i * 3), 0, 1, 1);
         check("fill_out_data", 32'(out_data), i);
         check("fill_in_ready", {31'b0, in_ready}, 32'h1);
      end
      step(0, 0, '0, '0, 0, 1, 1);
      check("drain_out_valid", {31'b0, out_valid}, 32'h0);
      check("drain_out_ctrl",  32'(out_ctrl), 32'h0);

      // Back-pressure: two words held, three more stalled cycles
      step(1, 0, '0, '0, 0, 0, 1);
      step(0, 1, 16'h00AA, 13'h0011, 0, 0, 1);
      step(0, 1, 16'h00BB, 13'h0022, 0, 0, 1);
      check("bp_in_ready_two", {31'b0, in_ready}, 32'h0);
      for (int i = 0; i < 3; i++) step(0, 1, 16'h0EEE, 13'h0033, 0, 0, 1);
      check("bp_stall_cnt", 32'(stall_cnt), CNT_EN ? 32'd4 : 32'd0);
      check("bp_head_aa", 32'(out_data), 32'h00AA);
      step(0, 0, '0, '0, 0, 1, 1);
      check("bp_next_bb", 32'(out_data), 32'h00BB);
      check("bp_bb_valid", {31'b0, out_valid}, 32'h1);
      step(0, 0, '0, '0, 0, 1, 1);
      check("bp_drained", {31'b0, out_valid}, 32'h0);

      // Flush in TWO with a simultaneous offer of 0x00CC
      step(0, 1, 16'h0011, 13'h0101, 0, 0, 1);
      step(0, 1, 16'h0022, 13'h0202, 0, 0, 1);
      check("fl_in_ready_two", {31'b0, in_ready}, 32'h0);
      step(0, 1, 16'h00CC, 13'h0303, 1, 0, 1);
      check("fl_out_valid", {31'b0, out_valid}, 32'h0);
      check("fl_out_ctrl",  32'(out_ctrl), 32'h0);
      check("fl_in_ready",  {31'b0, in_ready}, 32'h1);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, '0, '0, 0, 1, 1);
         check("fl_no_cc", {31'b0, out_valid}, 32'h0);
      end

      // Reset while in ONE with an offer pending
      step(0, 1, 16'h0033, 13'h0404, 0, 0, 1);
      step(1, 1, 16'h0044, 13'h0505, 0, 0, 1);
      check("rone_out_valid", {31'b0, out_valid}, 32'h0);
      check("rone_out_data",  32'(out_data),  32'h0);
      check("rone_out_ctrl",  32'(out_ctrl),  32'h0);
      check("rone_stall_cnt", 32'(stall_cnt), 32'h0);
      check("rone_in_ready",  {31'b0, in_ready}, 32'h1);

      // Bubble: control all-ones on the input never leaks out
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 16'($urandom), ones_ctrl, 0, 1'($urandom), 1);
         check("bub_out_ctrl",  32'(out_ctrl), 32'h0);
         check("bub_out_valid", {31'b0, out_valid}, 32'h0);
      end

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         step(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 9) < 7),
              16'($urandom),
              13'($urandom),
              ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 9) < 6),
              1);
      end

      // Saturation: one word held under back-pressure for 70000 cycles
      step(1, 0, '0, '0, 0, 0, 1);
      step(0, 1, 16'h0055, 13'h0606, 0, 0, 1);
      for (int i = 0; i < 70000; i++) begin
         step(0, 0, '0, '0, 0, 0, (i % 8192) == 0);
      end
      check("sat_stall_cnt", 32'(stall_cnt), CNT_EN ? 32'h0000FFFF : 32'h0);
      check("sat_out_data",  32'(out_data),  32'h0055);
      step(0, 0, '0, '0, 1, 0, 1);
      check("sat_after_flush", 32'(stall_cnt), CNT_EN ? 32'h0000FFFF : 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_pipe_stage_reg
